rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter with a bounded hold time. It shares one downstream resource among four requesters and issues a registered one-hot grant, which is the 2-to-4 decode of the winning requester index. It sits in front of any shared combinational datapath in the design and sequences access so that only one requester drives it per cycle, with no starvation.

---
 rtl/rr_arbiter4.sv | 91 +++++++++
 tb/tb_rr_arbiter4.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time.
// Registered one-hot grant; outputs are decoded straight from state.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [7:0] LAST = 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d;

  logic       busy;
  logic       keep;
  logic [3:0] cand;
  logic       found;
  logic [1:0] win;
  logic [1:0] idx;

  assign busy = (state_q == GRANT);
  assign keep = busy & req[owner_q] & (cnt_q != LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      cnt_q   <= 8'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Rotating scan starting at ptr; the current owner is masked out
  // so a timed-out owner yields to anyone else waiting.
  always_comb begin
    cand = req;
    if (busy) cand[owner_q] = 1'b0;
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (keep) begin
      cnt_d = cnt_q + 8'd1;
    end else if (found) begin
      state_d = GRANT;
      owner_d = win;
      cnt_d   = 8'd0;
      ptr_d   = win + 2'd1;
    end else if (busy && req[owner_q]) begin
      cnt_d = 8'd0;
      ptr_d = owner_q + 2'd1;
    end else begin
      state_d = IDLE;
    end
  end

  assign grant     = busy ? (4'b0001 << owner_q) : 4'b0000;
  assign gnt_idx   = busy ? owner_q : 2'd0;
  assign gnt_valid = busy;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with MAX_HOLD=8 and MAX_HOLD=4 instances.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst8, rst4;
  logic [3:0] req8, req4;
  logic [3:0] grant8, grant4;
  logic [1:0] idx8, idx4;
  logic       val8, val4;

  int total;
  int bad;

  rr_arbiter4 #(.MAX_HOLD(8)) u8 (
    .clk(clk), .rst(rst8), .req(req8),
    .grant(grant8), .gnt_idx(idx8), .gnt_valid(val8)
  );

  rr_arbiter4 #(.MAX_HOLD(4)) u4 (
    .clk(clk), .rst(rst4), .req(req4),
    .grant(grant4), .gnt_idx(idx4), .gnt_valid(val4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] e;
    total = 0;
    bad   = 0;
    rst8  = 1'b1;
    rst4  = 1'b1;
    req8  = 4'b1111;
    req4  = 4'b0000;

    tick();
    tick();
    chk("rst_grant", grant8, 4'b0000);
    chk("rst_valid", {3'b0, val8}, 4'b0000);
    chk("rst_idx", {2'b0, idx8}, 4'b0000);

    req8 = 4'b0000;
    rst8 = 1'b0;
    tick();
    chk("idle_0", grant8, 4'b0000);
    tick();
    chk("idle_1", grant8, 4'b0000);

    req8 = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("single_g%0d", i), grant8, 4'b0100);
      chk($sformatf("single_i%0d", i), {2'b0, idx8}, 4'd2);
    end
    req8 = 4'b0000;
    tick();
    chk("single_drop", grant8, 4'b0000);
    chk("single_val", {3'b0, val8}, 4'b0000);

    req8 = 4'b0011;
    tick();
    chk("early_g0", grant8, 4'b0001);
    tick();
    chk("early_g1", grant8, 4'b0001);
    req8 = 4'b0010;
    tick();
    chk("switch_g", grant8, 4'b0010);
    chk("switch_v", {3'b0, val8}, 4'b0001);
    req8 = 4'b0001;
    tick();
    chk("wrap_scan", grant8, 4'b0001);
    chk("wrap_idx", {2'b0, idx8}, 4'd0);
    req8 = 4'b0000;
    tick();
    chk("early_idle", grant8, 4'b0000);

    req4 = 4'b1111;
    rst4 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      e = 4'b0001 << ((k / 4) % 4);
      chk($sformatf("rot_g%0d", k), grant4, e);
      chk($sformatf("rot_i%0d", k), {2'b0, idx4}, 4'((k / 4) % 4));
    end

    req4 = 4'b1000;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("tmo_g%0d", k), grant4, 4'b1000);
      chk($sformatf("tmo_v%0d", k), {3'b0, val4}, 4'b0001);
    end

    req8 = 4'b0010;
    tick();
    chk("pre_rst_g", grant8, 4'b0010);
    #2;
    rst8 = 1'b1;
    #1;
    chk("async_g", grant8, 4'b0000);
    chk("async_v", {3'b0, val8}, 4'b0000);
    chk("async_i", {2'b0, idx8}, 4'd0);
    req8 = 4'b1111;
    #1;
    rst8 = 1'b0;
    tick();
    chk("post_rst_g", grant8, 4'b0001);
    chk("post_rst_i", {2'b0, idx8}, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
